// File: rtl/step_record_sequencer.sv
// Step record sequencer: pops 16-bit motion records ({mask, interval}) from the
// record FIFO and plays each one out. A record drives its mask on the step pins
// for PULSE_CYCLES clocks. It then dwells until the record length has elapsed,
// and then the next record is fetched. A sticky flag is raised when the FIFO
// runs dry before an end-of-move record (interval 0) has been seen.
module step_record_sequencer #(
  parameter int AXES         = 8,
  parameter int PULSE_CYCLES = 32,
  parameter int TICK_DIV     = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  input  logic [15:0]     fifo_data,
  output logic [AXES-1:0] step_out,
  output logic            busy,
  output logic            underrun,
  input  logic            clear_underrun,
  output logic [15:0]     record_count
);

  // Wide enough for the longest record (255 ticks) plus the pulse, with headroom.
  localparam int CNT_W = $clog2(255 * TICK_DIV + PULSE_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN
  } state_t;

  state_t           state;
  logic [AXES-1:0]  mask_r;
  logic [CNT_W-1:0] last_r;
  logic             ivl_nz_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Index of the final cycle of a record: max(PULSE_CYCLES, ivl*TICK_DIV) - 1.
  function automatic logic [CNT_W-1:0] record_last(input logic [7:0] ivl);
    logic [CNT_W-1:0] span;
    span = CNT_W'(ivl) * CNT_W'(TICK_DIV);
    if (span < CNT_W'(PULSE_CYCLES)) begin
      span = CNT_W'(PULSE_CYCLES);
    end
    return span - CNT_W'(1);
  endfunction

  assign cnt_next = cnt + CNT_W'(1);

  // Record datapath: latch the popped record in LOAD, count cycles through RUN.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      mask_r   <= fifo_data[8 +: AXES];
      last_r   <= record_last(fifo_data[7:0]);
      ivl_nz_r <= |fifo_data[7:0];
      cnt      <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt_next;
    end
  end

  // Sequencer FSM with registered strobe, step pins, status and record counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fifo_rd_en   <= 1'b0;
      step_out     <= '0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      record_count <= 16'd0;
    end else begin
      fifo_rd_en <= 1'b0;
      // A set later in this block overrides the clear.
      if (clear_underrun) begin
        underrun <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          // Pins go high together with the first RUN cycle.
          state    <= S_RUN;
          step_out <= fifo_data[8 +: AXES];
        end
        S_RUN: begin
          if (cnt == last_r) begin
            record_count <= record_count + 16'd1;
            step_out     <= '0;
            if (enable && !fifo_empty) begin
              state      <= S_FETCH;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
            if (enable && fifo_empty && ivl_nz_r) begin
              underrun <= 1'b1;
            end
          end else if (cnt_next >= CNT_W'(PULSE_CYCLES)) begin
            step_out <= '0;
          end else begin
            step_out <= mask_r;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          step_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_record_sequencer.sv
// Directed bench for step_record_sequencer with a small pointer-based FIFO model.
module tb_step_record_sequencer;

  localparam int AXES = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [15:0]     fifo_data = 16'h0000;
  logic [AXES-1:0] step_out;
  logic            busy;
  logic            underrun;
  logic            clear_underrun = 1'b0;
  logic [15:0]     record_count;

  // Second instance with a long pulse, fed directly by the bench.
  logic            en2 = 1'b0;
  logic            empty2 = 1'b1;
  logic            rd2;
  logic [15:0]     data2 = 16'h0100;
  logic [AXES-1:0] step2;
  logic            busy2;
  logic            und2;
  logic [15:0]     cnt2;

  int checks = 0;
  int errors = 0;

  // FIFO model: bench writes recs/wr_ptr, the pop process owns rd_ptr/bad_pop.
  logic [15:0] recs [8];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int bad_pop = 0;

  // Observation results.
  int obs_len, obs_rd, obs_hi, obs_nrise, obs_to;
  int obs_rise [4];

  always #5 clk = ~clk;

  step_record_sequencer #(.AXES(AXES), .PULSE_CYCLES(4), .TICK_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .step_out(step_out),
    .busy(busy), .underrun(underrun), .clear_underrun(clear_underrun),
    .record_count(record_count)
  );

  step_record_sequencer #(.AXES(AXES), .PULSE_CYCLES(16), .TICK_DIV(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .fifo_empty(empty2),
    .fifo_rd_en(rd2), .fifo_data(data2), .step_out(step2),
    .busy(busy2), .underrun(und2), .clear_underrun(1'b0),
    .record_count(cnt2)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read side: data appears one cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) begin
        bad_pop <= bad_pop + 1;
      end else begin
        fifo_data <= recs[rd_ptr % 8];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    recs[wr_ptr % 8] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    clear_underrun = 1'b0;
    rst_n = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Follow one busy period; index 0 is the first busy (FETCH) cycle.
  task automatic observe(input int drop_at, input int budget);
    logic [AXES-1:0] prev;
    bit started;
    prev = '0;
    started = 1'b0;
    obs_len = 0; obs_rd = 0; obs_hi = 0; obs_nrise = 0; obs_to = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy) begin
        started = 1'b1;
        if (fifo_rd_en) obs_rd++;
        if (step_out != '0) begin
          obs_hi++;
          if (prev == '0 && obs_nrise < 4) begin
            obs_rise[obs_nrise] = obs_len;
            obs_nrise++;
          end
        end
        prev = step_out;
        if (obs_len == drop_at) enable = 1'b0;
        obs_len++;
      end else if (started) begin
        obs_to = 0;
        return;
      end
    end
  endtask

  initial begin
    int pops0, seen, len2, hi2;
    bit st2;

    // 1: reset with a non-empty FIFO, then no pops while disabled.
    push(16'hA503); push(16'h0102); push(16'h0200); push(16'h0305);
    repeat (2) @(negedge clk);
    chk("rst_step", step_out, 0);
    chk("rst_rd", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", record_count, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pops0 = rd_ptr;
    repeat (10) @(negedge clk);
    chk("idle_no_pop", rd_ptr - pops0, 0);
    chk("idle_busy", busy, 0);

    // 2: single record A503 -> 4-cycle pulse, 30-cycle record, underrun.
    do_reset();
    push(16'hA503);
    enable = 1'b1;
    observe(-1, 100);
    chk("t2_done", obs_to, 0);
    chk("t2_busy_len", obs_len, 32);
    chk("t2_rd_pulses", obs_rd, 1);
    chk("t2_hi_cycles", obs_hi, 4);
    chk("t2_first_hi", obs_rise[0], 2);
    chk("t2_count", record_count, 1);
    chk("t2_underrun", underrun, 1);
    enable = 1'b0;

    // 3: 0102 then 0200 -> 22-cycle spacing, end-of-move leaves no underrun.
    do_reset();
    push(16'h0102); push(16'h0200);
    enable = 1'b1;
    observe(-1, 100);
    chk("t3_done", obs_to, 0);
    chk("t3_nrise", obs_nrise, 2);
    chk("t3_spacing", obs_rise[1] - obs_rise[0], 22);
    chk("t3_busy_len", obs_len, 28);
    chk("t3_hi_cycles", obs_hi, 8);
    chk("t3_rd_pulses", obs_rd, 2);
    chk("t3_underrun", underrun, 0);
    chk("t3_count", record_count, 2);
    enable = 1'b0;

    // 4: asynchronous reset on the second pulse cycle.
    do_reset();
    push(16'hFF05);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (step_out == 8'hFF) seen = 1;
    end
    chk("t4_pulse_seen", seen, 1);
    @(negedge clk);
    chk("t4_second_cycle", step_out, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("t4_async_step", step_out, 0);
    chk("t4_async_busy", busy, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_idle_after", busy, 0);
    chk("t4_step_after", step_out, 0);

    // 5: enable dropped on cycle 10 of 0305 with three records queued.
    do_reset();
    push(16'h0305); push(16'h0101); push(16'h0101); push(16'h0101);
    pops0 = rd_ptr;
    enable = 1'b1;
    observe(11, 150);
    chk("t5_done", obs_to, 0);
    chk("t5_busy_len", obs_len, 52);
    chk("t5_hi_cycles", obs_hi, 4);
    repeat (20) @(negedge clk);
    chk("t5_pops", rd_ptr - pops0, 1);
    chk("t5_underrun", underrun, 0);
    chk("t5_count", record_count, 1);
    chk("t5_idle", busy, 0);

    // 6a: 0001 -> pure dwell of 10 cycles; set beats a concurrent clear.
    do_reset();
    push(16'h0001);
    enable = 1'b1;
    clear_underrun = 1'b1;
    observe(-1, 60);
    chk("t6_done", obs_to, 0);
    chk("t6_busy_len", obs_len, 12);
    chk("t6_hi_cycles", obs_hi, 0);
    chk("t6_set_wins", underrun, 1);
    @(negedge clk);
    chk("t6_cleared", underrun, 0);
    clear_underrun = 1'b0;
    enable = 1'b0;

    // 6b: 0100 with a 16-cycle pulse -> record length 16.
    @(negedge clk);
    en2 = 1'b1;
    empty2 = 1'b0;
    len2 = 0; hi2 = 0; st2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd2) empty2 = 1'b1;
      if (busy2) begin
        st2 = 1'b1;
        len2++;
        if (step2 == 8'h01) hi2++;
      end else if (st2) begin
        break;
      end
    end
    chk("t6b_busy_len", len2, 18);
    chk("t6b_hi_cycles", hi2, 16);
    chk("t6b_underrun", und2, 0);
    chk("t6b_count", cnt2, 1);
    en2 = 1'b0;

    chk("no_pop_when_empty", bad_pop, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
